// File: rtl/parse_big_field_table.sv
// parse_big_field_table: reassembles one FIELD_LEN-beat AXI-stream frame into a wide value and publishes it atomically.
// Ports:
//   clock, rst         - block clock; synchronous active-high reset
//   enable             - sampled on beat 0 of a frame; 0 consumes and discards that frame
//   cm_tb_axis_*       - stream slave (tvalid/tready/tdata/tlast); tready = ~rst
//   value, value_vld   - last complete field (first beat in MSBs) and its one-cycle update pulse
//   short_err/long_err - one-cycle framing error pulses
// Build option: define PARSE_BIG_FIELD_LAST_CHK_EN to enable tlast framing checks (DROP state, error pulses).
// Without it, tlast is ignored and every FIELD_LEN beats form one frame.
module parse_big_field_table #(
    parameter int DSIZE     = 8,
    parameter int FIELD_LEN = 16*8,
    parameter     FIELD_NAME = "Big Filed"
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       cm_tb_axis_tvalid,
    output logic                       cm_tb_axis_tready,
    input  logic [DSIZE-1:0]           cm_tb_axis_tdata,
    input  logic                       cm_tb_axis_tlast,
    output logic [DSIZE*FIELD_LEN-1:0] value,
    output logic                       value_vld,
    output logic                       short_err,
    output logic                       long_err
);
    localparam int W = DSIZE*FIELD_LEN;
    localparam int CW = $clog2(FIELD_LEN+1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FIELD_LEN-1);

    if (FIELD_LEN < 1 || FIELD_LEN > 128) begin : g_bad_len
        $error("%s: FIELD_LEN=%0d outside 1..128", FIELD_NAME, FIELD_LEN);
    end

`ifdef PARSE_BIG_FIELD_LAST_CHK_EN
    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

    state_t          state_q, state_d;
    logic [W-1:0]    shadow_q, shadow_d, value_q, value_d;
    logic [CW-1:0]   cnt_q, cnt_d, idx;
    logic            en_lat_q, en_lat_d, vld_q, vld_d, serr_q, serr_d, lerr_q, lerr_d;
    logic            beat, en_cur, at_end, last;
    logic            unused_sink;

    assign cm_tb_axis_tready = ~rst;
    assign beat = cm_tb_axis_tvalid & cm_tb_axis_tready;
    // tlast is ignored in the unframed build and FIELD_NAME only feeds diagnostics
    assign unused_sink = ^{cm_tb_axis_tlast, FIELD_NAME};

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        value_d  = value_q;
        cnt_d    = cnt_q;
        en_lat_d = en_lat_q;
        vld_d    = 1'b0;
        serr_d   = 1'b0;
        lerr_d   = 1'b0;
        // beat index and enable as seen by the beat being taken now
        idx      = (state_q == IDLE) ? '0 : cnt_q;
        en_cur   = (state_q == IDLE) ? enable : en_lat_q;
        at_end   = (idx == LAST_IDX);
`ifdef PARSE_BIG_FIELD_LAST_CHK_EN
        last     = cm_tb_axis_tlast;
`else
        last     = at_end;
`endif
        if (beat) begin
`ifdef PARSE_BIG_FIELD_LAST_CHK_EN
            if (state_q == DROP) begin
                if (last) begin
                    lerr_d  = en_lat_q;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end else
`endif
            begin
                // shift-in assembly: after FIELD_LEN beats the first beat sits in the MSBs
                shadow_d = (state_q == IDLE) ? W'(cm_tb_axis_tdata)
                                             : (shadow_q << DSIZE) | W'(cm_tb_axis_tdata);
                cnt_d    = idx + 1'b1;
                en_lat_d = en_cur;
                if (at_end && last) begin
                    value_d = en_cur ? shadow_d : value_q;
                    vld_d   = en_cur;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`ifdef PARSE_BIG_FIELD_LAST_CHK_EN
                else if (last) begin
                    serr_d  = en_cur;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = DROP;
                end
`endif
                else begin
                    state_d = RECV;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            value_q  <= '0;
            cnt_q    <= '0;
            en_lat_q <= 1'b0;
            vld_q    <= 1'b0;
            serr_q   <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            value_q  <= value_d;
            cnt_q    <= cnt_d;
            en_lat_q <= en_lat_d;
            vld_q    <= vld_d;
            serr_q   <= serr_d;
            lerr_q   <= lerr_d;
        end
    end

    assign value     = value_q;
    assign value_vld = vld_q;
    assign short_err = serr_q;
    assign long_err  = lerr_q;
endmodule

// File: tb/tb_parse_big_field_table.sv
// tb_parse_big_field_table: randomized frame-level checking of parse_big_field_table at FIELD_LEN 4 and 128.
module tb_parse_big_field_table;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en4, v4, l4, r4, vld4, se4, le4;
    logic [7:0] d4;
    logic [31:0] val4;
    logic en8, v8, l8, r8, vld8, se8, le8;
    logic [7:0] d8;
    logic [1023:0] val8;

    int n_chk = 0, n_fail = 0;
    logic [7:0] fb[$];
    logic [7:0] frm[$];
    logic [7:0] big[128];
    logic fen;
    logic [1023:0] mval4, mval8, saved;
    logic [2:0] mpulse;

    parse_big_field_table #(.DSIZE(8), .FIELD_LEN(4)) u4 (
        .clock(clk), .rst(rst), .enable(en4),
        .cm_tb_axis_tvalid(v4), .cm_tb_axis_tready(r4), .cm_tb_axis_tdata(d4), .cm_tb_axis_tlast(l4),
        .value(val4), .value_vld(vld4), .short_err(se4), .long_err(le4)
    );

    parse_big_field_table #(.DSIZE(8), .FIELD_LEN(128)) u128 (
        .clock(clk), .rst(rst), .enable(en8),
        .cm_tb_axis_tvalid(v8), .cm_tb_axis_tready(r8), .cm_tb_axis_tdata(d8), .cm_tb_axis_tlast(l8),
        .value(val8), .value_vld(vld8), .short_err(se8), .long_err(le8)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        fb.delete();
        fen = 1'b0;
        mval4 = '0;
        mval8 = '0;
        mpulse = 3'b000;
    endfunction

    // frame-level reference: collect beats, then judge the frame by its length alone
    function automatic void model_beat(input int sel, input logic [7:0] d, input logic last, input logic en);
        int len = (sel != 0) ? 128 : 4;
        logic [1023:0] cat = '0;
        logic done;
        mpulse = 3'b000;
        if (fb.size() == 0) fen = en;
        fb.push_back(d);
`ifdef PARSE_BIG_FIELD_LAST_CHK_EN
        done = last;
`else
        done = (fb.size() == len);
`endif
        if (done) begin
            if (fb.size() == len) begin
                foreach (fb[i]) cat = {cat[1015:0], fb[i]};
                if (fen) begin
                    mpulse = 3'b100;
                    if (sel != 0) mval8 = cat; else mval4 = cat;
                end
            end else if (fb.size() < len) mpulse = {1'b0, fen, 1'b0};
            else mpulse = {2'b00, fen};
            fb.delete();
        end
    endfunction

    task automatic check_outs(input int sel);
        if (sel == 0) begin
            check("pulse4", {vld4, se4, le4}, mpulse);
            check("value4", val4, mval4[31:0]);
            check("tready4", r4, 1'b1);
        end else begin
            check("pulse128", {vld8, se8, le8}, mpulse);
            check("tready128", r8, 1'b1);
            for (int i = 0; i < 8; i++)
                check($sformatf("value128[%0d]", i), val8[i*128 +: 128], mval8[i*128 +: 128]);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic last, input logic en, input int maxgap);
        int g = $urandom_range(maxgap, 0);
        repeat (g) begin
            @(posedge clk);
            mpulse = 3'b000;
            @(negedge clk);
            check_outs(sel);
        end
        if (sel == 0) begin v4 = 1'b1; d4 = d; l4 = last; en4 = en; end
        else begin v8 = 1'b1; d8 = d; l8 = last; en8 = en; end
        @(posedge clk);
        model_beat(sel, d, last, en);
        @(negedge clk);
        v4 = 1'b0;
        v8 = 1'b0;
        check_outs(sel);
    endtask

    task automatic send_frame(input int sel, input logic en_first, input logic en_rest, input int maxgap, input logic use_last);
        foreach (frm[i]) send(sel, frm[i], use_last && (i == frm.size()-1), (i == 0) ? en_first : en_rest, maxgap);
    endtask

    // one reset cycle with junk traffic offered; none of it may be taken
    task automatic do_reset();
        rst = 1'b1;
        v4 = 1'b1; d4 = 8'hFF; l4 = 1'b1; en4 = 1'b1;
        v8 = 1'b1; d8 = 8'hFF; l8 = 1'b1; en8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_tready4", r4, 1'b0);
        check("rst_tready128", r8, 1'b0);
        check("rst_outs4", {val4, vld4, se4, le4}, '0);
        check("rst_outs128", {vld8, se8, le8, |val8}, '0);
        rst = 1'b0;
        v4 = 1'b0;
        v8 = 1'b0;
        model_clear();
    endtask

    initial begin
        rst = 1'b1;
        v4 = 1'b0; d4 = '0; l4 = 1'b0; en4 = 1'b0;
        v8 = 1'b0; d8 = '0; l8 = 1'b0; en8 = 1'b0;
        model_clear();
        do_reset();

        frm = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(0, 1'b1, 1'b1, 0, 1'b1);
        check("t1_value", val4, 32'h11223344);
        check("t1_vld", vld4, 1'b1);

        frm = '{8'hAA, 8'hBB};
        send_frame(0, 1'b1, 1'b1, 0, 1'b1);
        frm = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(0, 1'b1, 1'b1, 0, 1'b1);
`ifdef PARSE_BIG_FIELD_LAST_CHK_EN
        check("t2_value", val4, 32'h01020304);
`endif

        frm = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(0, 1'b1, 1'b1, 1, 1'b1);

        frm = '{8'h05, 8'h06, 8'h07, 8'h08};
        send_frame(0, 1'b0, 1'b1, 1, 1'b1);
        frm = '{8'h09, 8'h0A, 8'h0B, 8'h0C};
        send_frame(0, 1'b1, 1'b1, 1, 1'b1);

        send(0, 8'h55, 1'b0, 1'b1, 0);
        send(0, 8'h66, 1'b0, 1'b1, 0);
        do_reset();
        frm = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(0, 1'b1, 1'b1, 0, 1'b1);
        check("t5_value", val4, 32'hDEADBEEF);

        repeat (25) begin
            int n = $urandom_range(6, 1);
            frm.delete();
            repeat (n) frm.push_back(8'($urandom));
            send_frame(0, 1'($urandom), 1'($urandom), 2, 1'b1);
        end

        do_reset();
        frm.delete();
        for (int i = 0; i < 128; i++) begin
            big[i] = 8'($urandom);
            frm.push_back(big[i]);
        end
        send_frame(1, 1'b1, 1'b1, 3, 1'b1);
        check("t6_msb", val8[1023 -: 8], big[0]);
        check("t6_lsb", val8[7:0], big[127]);
        saved = val8;
`ifndef PARSE_BIG_FIELD_LAST_CHK_EN
        do_reset();
        send_frame(1, 1'b1, 1'b1, 3, 1'b0);
        check("t6_nolast_hi", val8[1023:512], saved[1023:512]);
        check("t6_nolast_lo", val8[511:0], saved[511:0]);
`endif
        frm.delete();
        repeat (128) frm.push_back(8'($urandom));
        send_frame(1, 1'b1, 1'b1, 1, 1'b1);
`ifdef PARSE_BIG_FIELD_LAST_CHK_EN
        frm = '{8'h01, 8'h02, 8'h03};
        send_frame(1, 1'b1, 1'b1, 1, 1'b1);
`endif
        repeat (3) begin
            @(posedge clk);
            mpulse = 3'b000;
            @(negedge clk);
            check_outs(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
